// File: rtl/frame_packetizer.sv
// frame_packetizer: packs a {r,g,b} pixel stream into fixed-size UDP payloads (8-byte header + CHUNK_PIX pixels)
// clk, rstn                 : single clock, synchronous active-low reset
// s_valid/s_ready/s_data    : pixel stream in, s_sof/s_eol frame and line markers
// m_valid/m_ready/m_data    : payload byte stream out, m_last on the final byte, m_len constant payload length
// frame_id, err_align       : current frame id, one-cycle marker misalignment pulse
// drop_cnt                  : saturating count of pixels discarded while unsynced
module frame_packetizer #(
  parameter int PIX_BYTES = 3,
  parameter int H_ACTIVE = 1280,
  parameter int CHUNK_PIX = 320,
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        s_eol,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic [15:0] m_len,
  output logic [15:0] frame_id,
  output logic        err_align,
  output logic [15:0] drop_cnt
);
  localparam int IW = $clog2(H_ACTIVE + 1);
  localparam int CW = $clog2(CHUNK_PIX) + 1;
  localparam logic [1:0] PB = 2'(PIX_BYTES);
  typedef enum logic [2:0] {UNSYNC, IDLE, HDR, LOAD, PIX} state_t;
  state_t state_q, state_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, err_q, err_d, sof_pend_q, sof_pend_d;
  logic [7:0] m_data_q, m_data_d;
  logic [15:0] drop_q, drop_d, fid_q, fid_d, line_q, line_d, off_q, off_d;
  logic [IW-1:0] in_line_q, in_line_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] pix_q, pix_d;
  logic [63:0] hdr;
  logic acc, last_b, chunk_end, line_end;
  function automatic logic [7:0] pix_byte(input logic [23:0] p, input logic [1:0] b);
    if (PIX_BYTES == 2) return b == 2'd0 ? {p[23:19], p[15:13]} : {p[12:10], p[7:3]};
    return b == 2'd0 ? p[23:16] : b == 2'd1 ? p[15:8] : p[7:0];
  endfunction
  assign hdr = {MAGIC, 6'b0, PB, fid_q, line_q, off_q};
  assign acc = m_valid_q && m_ready;
  assign last_b = bcnt_q == 2'(PIX_BYTES - 1);
  assign chunk_end = pix_cnt_q == CW'(CHUNK_PIX - 1);
  assign line_end = in_line_q == IW'(H_ACTIVE - 1);
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_last = m_last_q;
  assign m_len = 16'(8 + CHUNK_PIX * PIX_BYTES);
  assign frame_id = fid_q;
  assign err_align = err_q;
  assign drop_cnt = drop_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= UNSYNC;
      m_valid_q <= 1'b0;
      m_data_q <= 8'd0;
      m_last_q <= 1'b0;
      err_q <= 1'b0;
      sof_pend_q <= 1'b0;
      drop_q <= 16'd0;
      fid_q <= 16'hFFFF;
      line_q <= 16'd0;
      off_q <= 16'd0;
      in_line_q <= '0;
      pix_cnt_q <= '0;
      hcnt_q <= 4'd0;
      bcnt_q <= 2'd0;
      pix_q <= 24'd0;
    end else begin
      state_q <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
      err_q <= err_d;
      sof_pend_q <= sof_pend_d;
      drop_q <= drop_d;
      fid_q <= fid_d;
      line_q <= line_d;
      off_q <= off_d;
      in_line_q <= in_line_d;
      pix_cnt_q <= pix_cnt_d;
      hcnt_q <= hcnt_d;
      bcnt_q <= bcnt_d;
      pix_q <= pix_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNSYNC: state_d = s_valid && s_sof ? IDLE : UNSYNC;
      IDLE:   state_d = s_valid ? HDR : IDLE;
      HDR:    state_d = acc && hcnt_q == 4'd8 ? LOAD : HDR;
      LOAD:   state_d = s_valid ? PIX : LOAD;
      PIX:    state_d = !(acc && last_b) ? PIX : chunk_end ? IDLE : s_valid ? PIX : LOAD;
      default: state_d = UNSYNC;
    endcase
  end
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    err_d = 1'b0;
    sof_pend_d = sof_pend_q;
    drop_d = drop_q;
    fid_d = fid_q;
    line_d = line_q;
    off_d = off_q;
    in_line_d = in_line_q;
    pix_cnt_d = pix_cnt_q;
    hcnt_d = hcnt_q;
    bcnt_d = bcnt_q;
    pix_d = pix_q;
    s_ready = 1'b0;
    case (state_q)
      UNSYNC: begin
        // a start-of-frame pixel is left on the bus so IDLE can peek it
        s_ready = !s_sof;
        if (s_valid && !s_sof && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
      IDLE: if (s_valid) begin
        m_valid_d = 1'b1;
        m_data_d = MAGIC;
        m_last_d = 1'b0;
        hcnt_d = 4'd1;
        pix_cnt_d = '1;
        sof_pend_d = s_sof;
        if (s_sof) begin
          fid_d = fid_q + 16'd1;
          line_d = 16'd0;
          off_d = 16'd0;
          in_line_d = '0;
        end
      end
      HDR: if (acc) begin
        m_valid_d = hcnt_q != 4'd8;
        m_data_d = hdr[63 - 8 * hcnt_q[2:0] -: 8];
        hcnt_d = hcnt_q + 4'd1;
      end
      LOAD: s_ready = 1'b1;
      PIX: begin
        s_ready = m_ready && last_b && !chunk_end;
        if (acc && !last_b) begin
          bcnt_d = bcnt_q + 2'd1;
          m_data_d = pix_byte(pix_q, bcnt_q + 2'd1);
          m_last_d = chunk_end && bcnt_q + 2'd1 == 2'(PIX_BYTES - 1);
        end else if (acc) begin
          m_valid_d = 1'b0;
          m_last_d = 1'b0;
          // in_line already wrapped to 0 when the chunk closed the line
          if (chunk_end) begin
            line_d = in_line_q == '0 ? line_q + 16'd1 : line_q;
            off_d = in_line_q == '0 ? 16'd0 : off_q + 16'(CHUNK_PIX);
          end
        end
      end
      default: ;
    endcase
    if (s_valid && s_ready && (state_q == LOAD || state_q == PIX)) begin
      pix_d = s_data;
      bcnt_d = 2'd0;
      m_valid_d = 1'b1;
      m_data_d = pix_byte(s_data, 2'd0);
      m_last_d = 1'b0;
      pix_cnt_d = pix_cnt_q + CW'(1);
      in_line_d = line_end ? '0 : in_line_q + IW'(1);
      err_d = (s_eol != line_end) || (s_sof && !sof_pend_q);
      sof_pend_d = 1'b0;
    end
    s_ready = s_ready && rstn;
  end
endmodule

// File: tb/tb_frame_packetizer.sv
// tb_frame_packetizer: directed vector bench for frame_packetizer (RGB888 and RGB565 instances)
module tb_frame_packetizer;
  typedef struct { logic [23:0] d; logic sof; logic eol; } pix_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;
  logic s_valid, s_ready, s_sof, s_eol, m_valid, m_ready, m_last, err_align;
  logic [23:0] s_data;
  logic [7:0] m_data;
  logic [15:0] m_len, frame_id, drop_cnt;
  logic s_valid2, s_ready2, s_sof2, s_eol2, m_valid2, m_ready2, m_last2, err_align2;
  logic [23:0] s_data2;
  logic [7:0] m_data2;
  logic [15:0] m_len2, frame_id2, drop_cnt2;
  frame_packetizer #(.PIX_BYTES(3), .H_ACTIVE(8), .CHUNK_PIX(4), .MAGIC(8'hA5)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .s_eol(s_eol), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_len(m_len), .frame_id(frame_id), .err_align(err_align), .drop_cnt(drop_cnt));
  frame_packetizer #(.PIX_BYTES(2), .H_ACTIVE(8), .CHUNK_PIX(4), .MAGIC(8'hA5)) dut2 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_sof(s_sof2),
    .s_eol(s_eol2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
    .m_len(m_len2), .frame_id(frame_id2), .err_align(err_align2), .drop_cnt(drop_cnt2));
  int checks = 0, failures = 0, errs = 0;
  bit mon = 0, mon2 = 0, bp = 0;
  logic [8:0] got[$], got2[$], exp_q[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'd0;
  pix_t pv[16];
  logic [63:0] hv[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mon) begin
      if (prev_v && !prev_r) chk("stall_hold", {23'd0, m_valid, m_data}, {23'd0, 1'b1, prev_d});
      if (m_valid && m_ready) got.push_back({m_last, m_data});
      if (err_align) errs++;
    end
    if (mon2 && m_valid2 && m_ready2) got2.push_back({m_last2, m_data2});
    prev_v = m_valid;
    prev_r = m_ready;
    prev_d = m_data;
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (bp) m_ready = 1'($urandom_range(0, 1));
  end
  task automatic send(input logic [23:0] d, input logic sof, input logic eol);
    bit hs = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    for (int i = 0; i < 500 && !hs; i++) begin
      #1;
      hs = s_ready;
      @(negedge clk);
      #1;
    end
    if (!hs) chk("send_timeout", 0, 1);
  endtask
  task automatic send2(input logic [23:0] d, input logic sof);
    bit hs = 0;
    s_valid2 = 1'b1; s_data2 = d; s_sof2 = sof; s_eol2 = 1'b0;
    for (int i = 0; i < 500 && !hs; i++) begin
      #1;
      hs = s_ready2;
      @(negedge clk);
      #1;
    end
    if (!hs) chk("send2_timeout", 0, 1);
  endtask
  task automatic wait_bytes(input bit which, input int n);
    for (int i = 0; i < 3000 && (which ? got2.size() : got.size()) < n; i++) begin
      @(negedge clk);
      #1;
    end
    if ((which ? got2.size() : got.size()) < n) chk("byte_timeout", which ? got2.size() : got.size(), n);
  endtask
  task automatic push_hdr(input logic [63:0] h);
    for (int b = 0; b < 8; b++) exp_q.push_back({1'b0, h[63 - 8 * b -: 8]});
  endtask
  task automatic run(input string name, input int n, input logic [15:0] f, input bit bpf, input bit mis);
    got.delete();
    exp_q.delete();
    errs = 0;
    for (int k = 0; k < n / 4; k++) begin
      push_hdr(hv[k] | {16'd0, f, 32'd0});
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back({1'b0, pv[4 * k + j].d[23:16]});
        exp_q.push_back({1'b0, pv[4 * k + j].d[15:8]});
        exp_q.push_back({j == 3, pv[4 * k + j].d[7:0]});
      end
    end
    bp = bpf;
    mon = 1;
    for (int i = 0; i < n; i++) send(pv[i].d, i == 0, mis ? (i == 5 || i == 7) : pv[i].eol);
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    wait_bytes(0, n * 5);
    bp = 0;
    m_ready = 1'b1;
    mon = 0;
    chk($sformatf("%s_len", name), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), i < got.size() ? got[i] : 9'h1FF, exp_q[i]);
  endtask
  initial begin
    logic [8:0] e565[16];
    for (int i = 0; i < 16; i++) begin
      pv[i].d = 24'h102030 + 24'(i) * 24'h010101;
      pv[i].sof = i == 0;
      pv[i].eol = i == 7 || i == 15;
    end
    hv = '{64'hA503_0000_0000_0000, 64'hA503_0000_0000_0004, 64'hA503_0000_0001_0000, 64'hA503_0000_0001_0004};
    e565 = '{9'h0A5, 9'h002, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
             9'h0FC, 9'h008, 9'h000, 9'h01F, 9'h007, 9'h0E0, 9'h0F8, 9'h100};
    rstn = 1'b0;
    s_valid = 1'b0; s_data = 24'd0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
    s_valid2 = 1'b0; s_data2 = 24'd0; s_sof2 = 1'b0; s_eol2 = 1'b0; m_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_err", err_align, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_fid", frame_id, 16'hFFFF);
    chk("m_len888", m_len, 20);
    chk("m_len565", m_len2, 16);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("unsync_ready", s_ready, 1);
    for (int i = 0; i < 5; i++) send({16'd0, 8'(i)}, 1'b0, 1'b0);
    s_valid = 1'b0;
    chk("drop5", drop_cnt, 5);
    run("f0", 16, 16'd0, 0, 0);
    chk("f0_err", errs, 0);
    chk("f0_fid", frame_id, 0);
    chk("f0_drop", drop_cnt, 5);
    run("bp", 16, 16'd1, 1, 0);
    chk("bp_err", errs, 0);
    run("mis", 12, 16'd2, 0, 1);
    chk("mis_err", errs, 1);
    run("rec", 4, 16'd3, 0, 0);
    chk("rec_err", errs, 0);
    chk("rec_fid", frame_id, 3);
    got.delete();
    mon = 1;
    send(pv[0].d, 1'b1, 1'b0);
    s_valid = 1'b0; s_sof = 1'b0;
    wait_bytes(0, 11);
    chk("pre_rst_byte10", got.size() > 10 ? got[10] : 9'h1FF, 9'h030);
    rstn = 1'b0;
    mon = 0;
    @(negedge clk);
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_last", m_last, 0);
    chk("midrst_fid", frame_id, 16'hFFFF);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_drop", drop_cnt, 0);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_unsync_ready", s_ready, 1);
    chk("post_m_valid", m_valid, 0);
    send(24'h111111, 1'b0, 1'b0);
    s_valid = 1'b0;
    chk("post_drop", drop_cnt, 1);
    run("post", 4, 16'd0, 0, 0);
    chk("post_fid", frame_id, 0);
    mon2 = 1;
    send2(24'hFF8040, 1'b1);
    send2(24'h0000FF, 1'b0);
    send2(24'h00FC00, 1'b0);
    send2(24'hF80000, 1'b0);
    s_valid2 = 1'b0; s_sof2 = 1'b0;
    wait_bytes(1, 16);
    mon2 = 0;
    chk("p565_len", got2.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("p565_b%0d", i), i < got2.size() ? got2[i] : 9'h1FF, e565[i]);
    chk("p565_err", err_align2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
